mdu_sequencer: RTL and testbench

Multi-cycle controller for the multiply/divide unit in the E stage of the P6 pipeline. It accepts the MDU operation code decoded by the control unit, latches forwarded operands, and runs a busy counter of fixed length per operation class. It owns the HI/LO registers and raises a stall request toward the hazard unit while a later MDU-class instruction in D would observe an unfinished result.

---
 rtl/mdu_sequencer.sv | 152 +++++++++++++++
 tb/tb_mdu_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: owns HI/LO, times each op, requests D-stage stalls.
// Optional abort port and behaviour are enabled by defining MDU_FLUSH_EN.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_type,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_mdu_use,
`ifdef MDU_FLUSH_EN
    input  logic        flush,
`endif
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   counter;
    logic [31:0]        pending_hi;
    logic [31:0]        pending_lo;
    logic               pending_wr;
    logic               flush_act;
    logic               long_op;
    logic               is_div;
    logic [63:0]        result;
    logic               result_wr;

`ifdef MDU_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign long_op   = (mdu_type == OP_MULT) || (mdu_type == OP_MULTU) ||
                       (mdu_type == OP_DIV)  || (mdu_type == OP_DIVU);
    assign is_div    = (mdu_type == OP_DIV) || (mdu_type == OP_DIVU);
    assign start     = long_op && (state == IDLE) && !flush_act;
    assign stall_req = d_mdu_use && (start || busy);

    // Result is formed in the issue cycle from the forwarded operands; {hi, lo}.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        result    = 64'd0;
        result_wr = 1'b1;
        case (mdu_type)
            OP_MULT:  result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            OP_MULTU: result = {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) begin
                    result_wr = 1'b0;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    // The only signed overflow case: quotient wraps, remainder is zero.
                    result = {32'd0, 32'h8000_0000};
                end else begin
                    result = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    result_wr = 1'b0;
                end else begin
                    result = {a % b, a / b};
                end
            end
            default: result = 64'd0;
        endcase
    end

    always_comb begin
        mf_data = 32'd0;
        if (mdu_type == OP_MFHI) begin
            mf_data = hi;
        end else if (mdu_type == OP_MFLO) begin
            mf_data = lo;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            counter    <= '0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            pending_wr <= 1'b0;
        end else if (flush_act) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pending_hi <= result[63:32];
                        pending_lo <= result[31:0];
                        pending_wr <= result_wr;
                        counter    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy       <= 1'b1;
                        state      <= BUSY;
                    end else if (mdu_type == OP_MTHI) begin
                        hi <= a;
                    end else if (mdu_type == OP_MTLO) begin
                        lo <= a;
                    end
                end
                BUSY: begin
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        if (pending_wr) begin
                            hi <= pending_hi;
                            lo <= pending_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: op latency, HI/LO results, stall requests, reset mid-op.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_mdu_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mdu_type;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        d_mdu_use;
`ifdef MDU_FLUSH_EN
    logic        flush;
`endif
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .mdu_type  (mdu_type),
        .a         (op_a),
        .b         (op_b),
        .d_mdu_use (d_mdu_use),
`ifdef MDU_FLUSH_EN
        .flush     (flush),
`endif
        .start     (start),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .mf_data   (mf_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue a long op, count busy and stall cycles, then check HI/LO and the mf read path.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                          input logic [31:0] vb, input logic use_d, input int n,
                          input logic [31:0] old_hi, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int busy_cnt;
        int stall_cnt;
        next_cycle();
        mdu_type  = op;
        op_a      = va;
        op_b      = vb;
        d_mdu_use = use_d;
        @(negedge clk);
        check({tag, "_start"}, 32'(start), 32'd1);
        stall_cnt = stall_req ? 1 : 0;
        next_cycle();
        // An mthi arriving while busy must be ignored.
        mdu_type = 4'd7;
        op_a     = 32'hBADC_AFE0;
        busy_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, "_hold_hi"}, hi, old_hi);
            if (stall_req) stall_cnt++;
            if (busy !== 1'b1) break;
            busy_cnt++;
            next_cycle();
            mdu_type = 4'd0;
        end
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'(n));
        check({tag, "_stall_len"}, 32'(stall_cnt), use_d ? 32'(n + 1) : 32'd0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        mdu_type = 4'd5;
        #1;
        check({tag, "_mfhi"}, mf_data, exp_hi);
        mdu_type = 4'd6;
        #1;
        check({tag, "_mflo"}, mf_data, exp_lo);
        mdu_type  = 4'd0;
        d_mdu_use = 1'b0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        next_cycle();
        mdu_type = op;
        op_a     = val;
        next_cycle();
        mdu_type = (op == 4'd7) ? 4'd5 : 4'd6;
        @(negedge clk);
        check((op == 4'd7) ? "mthi_mf" : "mtlo_mf", mf_data, val);
        mdu_type = 4'd0;
    endtask

    initial begin
        reset     = 1'b1;
        mdu_type  = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        d_mdu_use = 1'b0;
`ifdef MDU_FLUSH_EN
        flush     = 1'b0;
`endif
        repeat (3) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);

        // Multiply: signed and unsigned interpretations of the same bits; stall with D use held.
        run_op("mult",  4'd1, 32'hFFFF_FFFD, 32'd5, 1'b1, MULT_N, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu", 4'd2, 32'hFFFF_FFFD, 32'd5, 1'b0, MULT_N, 32'hFFFF_FFFF, 32'h0000_0004, 32'hFFFF_FFF1);

        // Divide: unsigned, negative dividend, negative divisor.
        run_op("divu",  4'd4, 32'd7, 32'd2, 1'b1, DIV_N, 32'h0000_0004, 32'd1, 32'd3);
        run_op("div_n", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, DIV_N, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_d", 4'd3, 32'd7, 32'hFFFF_FFFE, 1'b0, DIV_N, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFD);

        // Divide by zero keeps the preset HI/LO; then the overflow case.
        move_to(4'd7, 32'h1234_5678);
        move_to(4'd8, 32'h1234_5678);
        run_op("div0",  4'd3, 32'd9, 32'd0, 1'b0, DIV_N, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678);
        run_op("divov", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, DIV_N, 32'h1234_5678, 32'd0, 32'h8000_0000);

        // Reset in the fourth cycle of a divide.
        move_to(4'd7, 32'hDEAD_BEEF);
        next_cycle();
        mdu_type = 4'd3;
        op_a     = 32'd100;
        op_b     = 32'd3;
        next_cycle();
        mdu_type = 4'd0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        mdu_type = 4'd5;
        #1;
        check("midrst_mfhi", mf_data, 32'd0);
        mdu_type = 4'd0;
        run_op("postrst", 4'd1, 32'd3, 32'd4, 1'b1, MULT_N, 32'd0, 32'd0, 32'd12);

`ifdef MDU_FLUSH_EN
        // Abort a multiply in its second busy cycle, then flush an mtlo in IDLE.
        next_cycle();
        mdu_type = 4'd1;
        op_a     = 32'd6;
        op_b     = 32'd7;
        next_cycle();
        mdu_type = 4'd0;
        next_cycle();
        flush = 1'b1;
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_lo", lo, 32'd12);
        repeat (MULT_N) next_cycle();
        @(negedge clk);
        check("flush_lo_late", lo, 32'd12);
        next_cycle();
        mdu_type = 4'd8;
        op_a     = 32'h0000_00AA;
        flush    = 1'b1;
        @(negedge clk);
        check("flush_start", 32'(start), 32'd0);
        next_cycle();
        flush    = 1'b0;
        mdu_type = 4'd0;
        @(negedge clk);
        check("flush_mtlo", lo, 32'd12);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
